// File: rtl/sysbus_interconnect.sv
// rtl/sysbus_interconnect.sv - system-bus region decoder, read-latency realignment and MMIO registers
// Every region answers exactly one cycle after the request; MMIO hosts display, 64-bit cycle counter and control.
module sysbus_interconnect #(
  parameter logic [3:0] GEMM_REGION = 4'h9,
  parameter logic [3:0] MMIO_REGION = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_rdwr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  input  logic [3:0]  cpu_mask,
  output logic [31:0] cpu_rd_data,
  output logic [31:0] dev_addr,
  output logic        dmem_en,
  input  logic [31:0] dmem_rd_data,
  output logic        gemm_en,
  input  logic [31:0] gemm_rd_data,
  output logic [31:0] display_data
);
  typedef enum logic [1:0] {SEL_DMEM = 2'd0, SEL_GEMM = 2'd1, SEL_MMIO = 2'd2} sel_t;

  sel_t        r_sel;
  logic [31:0] r_gemm_q;
  logic [31:0] r_mmio_q;
  logic [31:0] r_display;
  logic [63:0] r_cnt;
  logic [31:0] r_hi_snap;
  logic        r_cnt_en;
  logic        r_err;

  logic        w_is_gemm;
  logic        w_is_mmio;
  logic        w_mapped;
  logic [1:0]  w_off;
  logic        w_mmio_rd;
  logic        w_mmio_wr;
  logic        w_ctrl_wr;
  logic        w_cnt_clr;
  logic        w_err_set;
  logic        w_err_clr;
  logic [31:0] w_mmio_rdata;
  logic        w_unused;

  assign w_is_gemm = (cpu_addr[31:28] == GEMM_REGION);
  assign w_is_mmio = (cpu_addr[31:28] == MMIO_REGION);
  assign w_mapped  = (cpu_addr[27:4] == 24'd0);
  assign w_off     = cpu_addr[3:2];
  assign w_mmio_rd = cpu_en & w_is_mmio & ~cpu_rdwr;
  assign w_mmio_wr = cpu_en & w_is_mmio & cpu_rdwr & w_mapped;
  assign w_ctrl_wr = w_mmio_wr & (w_off == 2'd3);
  assign w_cnt_clr = w_ctrl_wr & cpu_mask[0] & cpu_wr_data[1];
  assign w_err_clr = w_ctrl_wr & cpu_mask[1] & cpu_wr_data[8];
  assign w_err_set = cpu_en & w_is_mmio & ~w_mapped;
  assign w_unused  = &{1'b0, cpu_addr[1:0]};

  assign dev_addr     = {cpu_addr[31:2], 2'b00};
  assign dmem_en      = cpu_en & rst & ~w_is_gemm & ~w_is_mmio;
  assign gemm_en      = cpu_en & rst & w_is_gemm;
  assign display_data = r_display;

  always_comb begin
    w_mmio_rdata = 32'd0;
    if (w_mapped) begin
      case (w_off)
        2'd0:    w_mmio_rdata = r_display;
        2'd1:    w_mmio_rdata = r_cnt[31:0];
        2'd2:    w_mmio_rdata = r_hi_snap;
        default: w_mmio_rdata = {23'd0, r_err, 7'd0, r_cnt_en};
      endcase
    end
  end

  // In reset the bus sees the RAM directly so no stale pending read can leak out.
  always_comb begin
    cpu_rd_data = dmem_rd_data;
    if (rst) begin
      case (r_sel)
        SEL_GEMM: cpu_rd_data = r_gemm_q;
        SEL_MMIO: cpu_rd_data = r_mmio_q;
        default:  cpu_rd_data = dmem_rd_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sel     <= SEL_DMEM;
      r_gemm_q  <= 32'd0;
      r_mmio_q  <= 32'd0;
      r_display <= 32'd0;
      r_cnt     <= 64'd0;
      r_hi_snap <= 32'd0;
      r_cnt_en  <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      if (cpu_en) begin
        r_sel <= w_is_gemm ? SEL_GEMM : (w_is_mmio ? SEL_MMIO : SEL_DMEM);
      end
      if (cpu_en && w_is_gemm) begin
        r_gemm_q <= gemm_rd_data;
      end
      // Snapshotting the high word with the low-word read keeps the 64-bit pair coherent.
      if (w_mmio_rd) begin
        r_mmio_q <= w_mmio_rdata;
        if (w_mapped && w_off == 2'd1) begin
          r_hi_snap <= r_cnt[63:32];
        end
      end
      if (w_mmio_wr && w_off == 2'd0) begin
        for (int i = 0; i < 4; i++) begin
          if (cpu_mask[i]) begin
            r_display[8*i +: 8] <= cpu_wr_data[8*i +: 8];
          end
        end
      end
      if (w_ctrl_wr && cpu_mask[0]) begin
        r_cnt_en <= cpu_wr_data[0];
      end
      if (w_cnt_clr) begin
        r_cnt <= 64'd0;
      end else if (r_cnt_en) begin
        r_cnt <= r_cnt + 64'd1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sysbus_interconnect.sv
// tb/tb_sysbus_interconnect.sv - scoreboard bench with a cycle-level behavioural model of the MMIO map
// Stimulus pushes expected read data; a negedge monitor pops and compares the cycle after each read.
module tb_sysbus_interconnect;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_en = 1'b0;
  logic        cpu_rdwr = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wr_data = 32'd0;
  logic [3:0]  cpu_mask = 4'd0;
  logic [31:0] cpu_rd_data;
  logic [31:0] dev_addr;
  logic        dmem_en;
  logic [31:0] dmem_rd_data = 32'd0;
  logic        gemm_en;
  logic [31:0] gemm_rd_data = 32'd0;
  logic [31:0] display_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  bit          pend = 1'b0;
  logic [31:0] e;

  logic [31:0]     m_display;
  longint unsigned m_cnt;
  logic [31:0]     m_hi;
  bit              m_cnt_en;
  bit              m_err;
  logic [31:0]     prev_addr = 32'd0;

  always #5 clk = ~clk;

  sysbus_interconnect dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_rdwr(cpu_rdwr), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_mask(cpu_mask), .cpu_rd_data(cpu_rd_data),
    .dev_addr(dev_addr), .dmem_en(dmem_en), .dmem_rd_data(dmem_rd_data),
    .gemm_en(gemm_en), .gemm_rd_data(gemm_rd_data), .display_data(display_data)
  );

  function automatic logic [31:0] dmem_f(logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD0001;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] gemm_f(logic [31:0] a);
    if (a == 32'h9000_0004) return 32'h0000BEEF;
    return {~a[15:0], a[31:16]} ^ 32'h2468_ACE0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit en, bit wr, logic [31:0] addr, logic [31:0] wd, logic [3:0] mask, bit rstv = 1'b1);
    logic [31:0] exp;
    bit clr, eset, eclr, nen;
    @(posedge clk);
    #1;
    rst = rstv; cpu_en = en; cpu_rdwr = wr; cpu_addr = addr; cpu_wr_data = wd; cpu_mask = mask;
    dmem_rd_data = dmem_f(prev_addr);
    gemm_rd_data = gemm_f(addr);
    prev_addr = addr;
    if (!rstv) begin
      m_display = 0; m_cnt = 0; m_hi = 0; m_cnt_en = 1; m_err = 0;
      return;
    end
    exp = 0; clr = 0; eset = 0; eclr = 0; nen = m_cnt_en;
    if (en) begin
      if (addr[31:28] == 4'h9) exp = gemm_f(addr);
      else if (addr[31:28] != 4'h8) exp = dmem_f(addr);
      else if (addr[27:4] != 0) eset = 1;
      else if (!wr) begin
        case (addr[3:2])
          2'd0: exp = m_display;
          2'd1: begin exp = m_cnt[31:0]; m_hi = m_cnt[63:32]; end
          2'd2: exp = m_hi;
          default: exp = {23'd0, m_err, 7'd0, m_cnt_en};
        endcase
      end else begin
        if (addr[3:2] == 2'd0) begin
          for (int i = 0; i < 4; i++) if (mask[i]) m_display[8*i +: 8] = wd[8*i +: 8];
        end else if (addr[3:2] == 2'd3) begin
          if (mask[0]) begin nen = wd[0]; clr = wd[1]; end
          if (mask[1] && wd[8]) eclr = 1;
        end
      end
      if (!wr) exp_q.push_back(exp);
    end
    if (clr) m_cnt = 0;
    else if (m_cnt_en) m_cnt = m_cnt + 1;
    m_cnt_en = nen;
    if (eset) m_err = 1;
    else if (eclr) m_err = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0000_0100, 0, 0);
  endtask

  always @(negedge clk) begin
    if (pend) begin
      pend = 0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow: got read return expected none");
      end else begin
        e = exp_q.pop_front();
        if (rst) check("rd_data", cpu_rd_data, e);
      end
    end
    if (!rst) check("rst_rd_passthru", cpu_rd_data, dmem_rd_data);
    check("dmem_en", {31'd0, dmem_en},
          {31'd0, cpu_en & rst & (cpu_addr[31:28] != 4'h8) & (cpu_addr[31:28] != 4'h9)});
    check("gemm_en", {31'd0, gemm_en}, {31'd0, cpu_en & rst & (cpu_addr[31:28] == 4'h9)});
    check("dev_addr", dev_addr, {cpu_addr[31:2], 2'b00});
    if (cpu_en && !cpu_rdwr && rst) pend = 1;
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  r;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h8000_000C, 0, 0, 0);
    drive(0, 0, 32'h8000_0000, 0, 0);
    drive(1, 0, 32'h8000_000C, 0, 0);
    drive(1, 0, 32'h8000_0000, 0, 0);
    idle(1);
    @(negedge clk);
    check("display_after_reset", display_data, 32'h0);

    drive(1, 1, 32'h8000_0000, 32'h11223344, 4'hF);
    drive(1, 1, 32'h8000_0000, 32'hAABBCCDD, 4'b0101);
    idle(1);
    @(negedge clk);
    check("display_masked", display_data, 32'h11BB33DD);

    drive(1, 0, 32'h0000_0010, 0, 0);
    drive(1, 0, 32'h9000_0004, 0, 0);
    drive(1, 0, 32'h8000_0000, 0, 0);
    idle(2);

    drive(1, 1, 32'h8000_000C, 32'h3, 4'h1);
    idle(5);
    drive(1, 1, 32'h8000_000C, 32'h0, 4'h1);
    drive(1, 0, 32'h8000_0004, 0, 0);
    drive(1, 0, 32'h8000_0008, 0, 0);
    drive(1, 1, 32'h8000_000C, 32'h3, 4'h1);
    drive(1, 0, 32'h8000_0004, 0, 0);
    drive(1, 1, 32'h8000_000C, 32'h3, 4'h1);
    drive(1, 0, 32'h8000_0004, 0, 0);
    drive(1, 0, 32'h8000_0008, 0, 0);

    drive(1, 0, 32'h8000_0040, 0, 0);
    drive(1, 0, 32'h8000_000C, 0, 0);
    drive(1, 1, 32'h8000_000C, 32'h100, 4'b0010);
    drive(1, 0, 32'h8000_000C, 0, 0);
    drive(1, 1, 32'h8000_004C, 32'h100, 4'b0010);
    drive(1, 0, 32'h8000_000C, 0, 0);

    drive(1, 1, 32'h8000_0000, 32'hCAFEF00D, 4'hF);
    drive(1, 0, 32'h8000_0000, 0, 0);
    drive(1, 0, 32'h0000_0010, 0, 0, 0);
    drive(1, 0, 32'h8000_0000, 0, 0);
    drive(1, 0, 32'h8000_000C, 0, 0);
    drive(1, 0, 32'h8000_0008, 0, 0);
    idle(1);
    @(negedge clk);
    check("display_after_mid_reset", display_data, 32'h0);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          r = 4'($urandom_range(0, 15));
          if (r == 4'h8 || r == 4'h9) r = r + 4'h4;
          a = {r, 28'($urandom)};
        end
        2: a = {4'h9, 28'($urandom)};
        3, 4: a = {4'h8, 24'd0, 4'($urandom)};
        default: a = {4'h8, 24'($urandom_range(1, 24'hFFFFFF)), 4'($urandom)};
      endcase
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a, $urandom, 4'($urandom),
            1'($urandom_range(0, 99) != 0));
    end
    idle(3);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
